// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial_deser receiver.
// States, default word width and bit-order encodings.
package serial_deser_pkg;

    localparam int unsigned DESER_WIDTH_DEFAULT = 4;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        PARITY = 2'd2
    } deser_state_e;

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register for completed words.
// A word arriving while the entry is full and not being consumed is dropped and flagged.
module deser_out_buf
    import serial_deser_pkg::*;
#(
    parameter int unsigned WIDTH = DESER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_err,
    input  logic             ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             err,
    output logic             overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        if (load) begin
            // The held word leaves on this edge if it is being consumed, freeing the slot.
            if (!valid_q || ready) begin
                data_d  = load_data;
                err_d   = load_err;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel receiver, MSB- or LSB-first, with a one-entry output buffer.
// Define SERIAL_DESER_PARITY_EN to expect a trailing even-parity bit per word.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int unsigned WIDTH = DESER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             msb_first,
    input  logic             flush,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    output logic             par_err
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    deser_state_e     state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             dir_q, dir_d;

    logic             dir_eff;
    logic [WIDTH-1:0] sr_shift;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             load_err;

    // The first bit of a word uses the live msb_first; later bits use the latched one.
    assign dir_eff  = (state_q == IDLE) ? msb_first : dir_q;
    assign sr_shift = (dir_eff == DIR_MSB) ? {sr_q[WIDTH-2:0], ser_in}
                                           : {ser_in, sr_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        dir_d     = dir_q;
        load      = 1'b0;
        load_data = sr_shift;
        load_err  = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (ser_valid) begin
            unique case (state_q)
                IDLE: begin
                    dir_d   = msb_first;
                    sr_d    = sr_shift;
                    cnt_d   = CntW'(1);
                    state_d = RECV;
                end
                RECV: begin
                    sr_d = sr_shift;
                    if (cnt_q == LastCnt) begin
`ifdef SERIAL_DESER_PARITY_EN
                        cnt_d   = CntW'(WIDTH);
                        state_d = PARITY;
`else
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PARITY: begin
`ifdef SERIAL_DESER_PARITY_EN
                    load      = 1'b1;
                    load_data = sr_q;
                    load_err  = ^{sr_q, ser_in};
`endif
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            dir_q   <= DIR_LSB;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            dir_q   <= dir_d;
        end
    end

    deser_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_data   (load_data),
        .load_err    (load_err),
        .ready       (par_ready),
        .clr_overrun (flush),
        .data        (par_out),
        .valid       (par_valid),
        .err         (par_err),
        .overrun     (overrun)
    );

endmodule

// File: tb/tb_serial_deser.sv
// Scoreboard bench for serial_deser: directed cases plus randomized bit streams.
// Honours SERIAL_DESER_PARITY_EN when defined.
module tb_serial_deser;

    localparam int unsigned WIDTH = 4;
`ifdef SERIAL_DESER_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ser_in = 1'b0;
    logic             ser_valid = 1'b0;
    logic             msb_first = 1'b0;
    logic             flush = 1'b0;
    logic             par_ready = 1'b0;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             overrun;
    logic             par_err;

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    // Reference model state: received bits of the current word, word order, buffer contents.
    logic           bits_q[$];
    logic           mdir;
    logic           mdl_valid = 1'b0;
    logic           mdl_ovr = 1'b0;
    logic [WIDTH:0] exp_q[$];

    serial_deser #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .msb_first (msb_first),
        .flush     (flush),
        .par_out   (par_out),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .overrun   (overrun),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies the receiver rules to the inputs present at the edge just taken.
    task automatic model_step();
        logic           hs;
        logic           done;
        logic [WIDTH-1:0] w;
        logic           e;
        hs   = mdl_valid && par_ready;
        done = 1'b0;
        w    = '0;
        e    = 1'b0;
        if (flush) begin
            bits_q.delete();
            mdl_ovr = 1'b0;
            if (hs) mdl_valid = 1'b0;
        end else begin
            if (ser_valid) begin
                if (bits_q.size() == 0) mdir = msb_first;
                bits_q.push_back(ser_in);
                if (bits_q.size() == NBITS) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (mdir) w[WIDTH-1-i] = bits_q[i];
                        else      w[i] = bits_q[i];
                    end
`ifdef SERIAL_DESER_PARITY_EN
                    e = (^w) ^ bits_q[WIDTH];
`endif
                    done = 1'b1;
                    bits_q.delete();
                end
            end
            if (done) begin
                if (!mdl_valid || par_ready) begin
                    exp_q.push_back({e, w});
                    mdl_valid = 1'b1;
                end else begin
                    mdl_ovr = 1'b1;
                end
            end else if (hs) begin
                mdl_valid = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_par_out", 32'(par_out), 32'd0);
        check("rst_par_valid", 32'(par_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_par_err", 32'(par_err), 32'd0);
        bits_q.delete();
        exp_q.delete();
        mdl_valid = 1'b0;
        mdl_ovr   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        ser_in    = b;
        ser_valid = 1'b1;
        cycle();
        ser_valid = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic m, input bit toggle);
        for (int i = 0; i < WIDTH; i++) begin
            msb_first = (toggle && i > 0) ? ~m : m;
            send_bit(m ? w[WIDTH-1-i] : w[i]);
        end
`ifdef SERIAL_DESER_PARITY_EN
        send_bit(^w);
`endif
    endtask

    task automatic drain();
        par_ready = 1'b1;
        ser_valid = 1'b0;
        cycle();
        par_ready = 1'b0;
    endtask

    // Monitor: compares flags every cycle and the word on every handshake.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (rst_n && started) begin
            check("par_valid", 32'(par_valid), 32'(mdl_valid));
            check("overrun", 32'(overrun), 32'(mdl_ovr));
            if (mdl_valid && par_ready) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_par_out", 32'(par_out), 32'(e[WIDTH-1:0]));
                    check("sb_par_err", 32'(par_err), 32'(e[WIDTH]));
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        started = 1'b1;

        // MSB-first 1,0,1,1
        send_word(4'b1011, 1'b1, 1'b0);
        check("msb_word", 32'(par_out), 32'h0000000b);
        check("msb_valid", 32'(par_valid), 32'd1);
        check("msb_overrun", 32'(overrun), 32'd0);
        drain();

        // LSB-first 1,0,1,1 with msb_first toggled after the first bit
        send_word(4'b1101, 1'b0, 1'b1);
        check("lsb_word", 32'(par_out), 32'h0000000d);
        drain();

        // Overrun, then flush clears it without touching the held word
        send_word(4'b0101, 1'b1, 1'b0);
        send_word(4'b0011, 1'b1, 1'b0);
        check("ovr_word_kept", 32'(par_out), 32'h00000005);
        check("ovr_flag", 32'(overrun), 32'd1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_ovr_clr", 32'(overrun), 32'd0);
        check("flush_valid_kept", 32'(par_valid), 32'd1);
        drain();

        // Back-to-back words with the consumer always ready
        par_ready = 1'b1;
        send_word(4'b1000, 1'b1, 1'b0);
        send_word(4'b0001, 1'b1, 1'b0);
        check("b2b_second", 32'(par_out), 32'h00000001);
        check("b2b_overrun", 32'(overrun), 32'd0);
        drain();

        // Flush beats a same-edge bit
        msb_first = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        flush     = 1'b1;
        ser_valid = 1'b1;
        ser_in    = 1'b1;
        cycle();
        flush     = 1'b0;
        ser_valid = 1'b0;
        send_word(4'b1110, 1'b1, 1'b0);
        check("flush_word", 32'(par_out), 32'h0000000e);
        drain();

        // Reset mid-word discards the partial word
        send_bit(1'b1);
        send_bit(1'b1);
        do_reset();
        send_word(4'b0110, 1'b0, 1'b0);
        check("post_rst_word", 32'(par_out), 32'h00000006);
        drain();

`ifdef SERIAL_DESER_PARITY_EN
        msb_first = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check("par_ok_word", 32'(par_out), 32'h0000000b);
        check("par_ok_err", 32'(par_err), 32'd0);
        drain();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("par_bad_err", 32'(par_err), 32'd1);
        drain();
`endif

        for (int i = 0; i < 600; i++) begin
            ser_valid = ($urandom_range(0, 9) < 6);
            ser_in    = 1'($urandom_range(0, 1));
            msb_first = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 39) == 0);
            par_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        ser_valid = 1'b0;
        flush     = 1'b0;
        drain();
        check("final_queue", 32'(exp_q.size()), 32'(mdl_valid));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
